// File: rtl/qos_pkg.sv
// Shared definitions for the QoS register block: address map,
// CONFIG field layout, reset defaults and the priority checker.
package qos_pkg;

    localparam logic [7:0] QOS_ADDR_CONFIG = 8'h00;
    localparam logic [7:0] QOS_ADDR_STATUS = 8'h01;
    localparam logic [7:0] QOS_ADDR_ERRCNT = 8'h02;

    localparam int CFG_FALLBACK_BIT = 0;
    localparam int CFG_MANUAL_BIT   = 1;
    localparam int CFG_MCH_LSB      = 2;
    localparam int CFG_PRIO_LSB     = 4;
    localparam int CFG_TIMER_LSB    = 12;
    localparam int STS_PRIO_ERR_BIT = 6;

    localparam logic [7:0]  PRIO_DEF      = 8'b11_10_01_00;
    localparam logic [19:0] RST_TIMER_DEF = 20'd50_000;

    // Packed MSB-first so a cast from the 32-bit bus word lines up
    typedef struct packed {
        logic [19:0] reset_timer;
        logic [7:0]  channel_priority;
        logic [1:0]  manual_channel;
        logic        manual_enable;
        logic        fallback_enable;
    } qos_cfg_t;

    function automatic logic prio_is_perm(input logic [7:0] p);
        logic [3:0] seen;
        seen = '0;
        for (int i = 0; i < 4; i++) begin
            seen[p[2*i +: 2]] = 1'b1;
        end
        return &seen;
    endfunction

endpackage

// File: rtl/qos_err_counter.sv
// Saturating per-channel error counter.
// A clear and an increment in the same cycle leave the count at 1.
module qos_err_counter #(
    parameter int W = 8
) (
    input  logic         rclk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] base;
    logic [W-1:0] nxt;

    always_comb begin
        base = clr ? '0 : cnt;
        nxt  = base;
        if (inc && (base != '1)) begin
            nxt = base + W'(1);
        end
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= nxt;
        end
    end

endmodule

// File: rtl/qos_mm_regs.sv
// QoS memory-mapped config/status responder in the rclk domain.
// Define QOS_ERRCNT_CLEAR_ON_READ_EN to make ERRCNT reads destructive.
module qos_mm_regs #(
    parameter int          CNT_W         = 8,
    parameter logic [19:0] RST_TIMER_DEF = qos_pkg::RST_TIMER_DEF,
    parameter logic [7:0]  PRIO_DEF      = qos_pkg::PRIO_DEF
) (
    input  logic        rclk,
    input  logic        rst_n,
    input  logic        mm_write_en,
    input  logic        mm_read_en,
    input  logic [7:0]  mm_addr,
    input  logic [31:0] mm_wdata,
    output logic [31:0] mm_rdata,
    input  logic [1:0]  active_channel,
    input  logic [3:0]  signal_present,
    input  logic [3:0]  err_inc,
    output logic        fallback_enable,
    output logic        manual_enable,
    output logic [1:0]  manual_channel,
    output logic [7:0]  channel_priority,
    output logic [19:0] reset_timer,
    output logic        cfg_update
);
    import qos_pkg::*;

    qos_cfg_t    cfg;
    qos_cfg_t    wcfg;
    logic        prio_err;
    logic        prio_ok;
    logic        sel_cfg, sel_sts, sel_err;
    logic        wr_cfg, wr_sts;
    logic        cnt_clr;
    logic [31:0] errcnt_word;
    logic [31:0] rd_next;
    logic [CNT_W-1:0] cnt [4];

    assign sel_cfg = (mm_addr == QOS_ADDR_CONFIG);
    assign sel_sts = (mm_addr == QOS_ADDR_STATUS);
    assign sel_err = (mm_addr == QOS_ADDR_ERRCNT);
    assign wr_cfg  = mm_write_en && sel_cfg;
    assign wr_sts  = mm_write_en && sel_sts;

    assign wcfg    = qos_cfg_t'(mm_wdata);
    assign prio_ok = prio_is_perm(wcfg.channel_priority);

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            cfg.fallback_enable  <= 1'b0;
            cfg.manual_enable    <= 1'b0;
            cfg.manual_channel   <= 2'd0;
            cfg.channel_priority <= PRIO_DEF;
            cfg.reset_timer      <= RST_TIMER_DEF;
            cfg_update           <= 1'b0;
        end else begin
            cfg_update <= wr_cfg && prio_ok;
            if (wr_cfg && prio_ok) begin
                cfg <= wcfg;
            end
        end
    end

    // A rejection in the same cycle as a W1C wins
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            prio_err <= 1'b0;
        end else begin
            prio_err <= (prio_err &&
                         !(wr_sts && mm_wdata[STS_PRIO_ERR_BIT]))
                        || (wr_cfg && !prio_ok);
        end
    end

`ifdef QOS_ERRCNT_CLEAR_ON_READ_EN
    assign cnt_clr = mm_read_en && sel_err;
`else
    assign cnt_clr = 1'b0;
`endif

    for (genvar i = 0; i < 4; i++) begin : g_cnt
        qos_err_counter #(.W(CNT_W)) u_cnt (
            .rclk  (rclk),
            .rst_n (rst_n),
            .inc   (err_inc[i]),
            .clr   (cnt_clr),
            .cnt   (cnt[i])
        );
        assign errcnt_word[8*i +: 8] = 8'(cnt[i]);
    end

    always_comb begin
        rd_next = '0;
        unique case (1'b1)
            sel_cfg: rd_next = 32'(cfg);
            sel_sts: rd_next = {25'd0, prio_err,
                                signal_present, active_channel};
            sel_err: rd_next = errcnt_word;
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            mm_rdata <= '0;
        end else if (mm_read_en) begin
            mm_rdata <= rd_next;
        end
    end

    assign fallback_enable  = cfg.fallback_enable;
    assign manual_enable    = cfg.manual_enable;
    assign manual_channel   = cfg.manual_channel;
    assign channel_priority = cfg.channel_priority;
    assign reset_timer      = cfg.reset_timer;

endmodule

// File: tb/tb_qos_mm_regs.sv
// Directed self-checking bench for qos_mm_regs.
// Inputs change on negedge; outputs are sampled on the following negedge.
module tb_qos_mm_regs;

    logic        rclk = 1'b0;
    logic        rst_n;
    logic        mm_write_en, mm_read_en;
    logic [7:0]  mm_addr;
    logic [31:0] mm_wdata, mm_rdata;
    logic [1:0]  active_channel;
    logic [3:0]  signal_present, err_inc;
    logic        fallback_enable, manual_enable, cfg_update;
    logic [1:0]  manual_channel;
    logic [7:0]  channel_priority;
    logic [19:0] reset_timer;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 rclk = ~rclk;

    qos_mm_regs dut (
        .rclk             (rclk),
        .rst_n            (rst_n),
        .mm_write_en      (mm_write_en),
        .mm_read_en       (mm_read_en),
        .mm_addr          (mm_addr),
        .mm_wdata         (mm_wdata),
        .mm_rdata         (mm_rdata),
        .active_channel   (active_channel),
        .signal_present   (signal_present),
        .err_inc          (err_inc),
        .fallback_enable  (fallback_enable),
        .manual_enable    (manual_enable),
        .manual_channel   (manual_channel),
        .channel_priority (channel_priority),
        .reset_timer      (reset_timer),
        .cfg_update       (cfg_update)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cfg_chk(input string tag, input logic [31:0] exp);
        chk(tag, {reset_timer, channel_priority, manual_channel,
                  manual_enable, fallback_enable}, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge rclk);
        mm_write_en = 1'b1;
        mm_addr     = a;
        mm_wdata    = d;
        @(negedge rclk);
        mm_write_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge rclk);
        mm_read_en = 1'b1;
        mm_addr    = a;
        @(negedge rclk);
        mm_read_en = 1'b0;
        d = mm_rdata;
    endtask

    task automatic pulse(input logic [3:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge rclk);
            err_inc = m;
        end
        @(negedge rclk);
        err_inc = 4'h0;
    endtask

    initial begin
        logic [31:0] d;
        rst_n = 1'b0;
        mm_write_en = 1'b0;
        mm_read_en = 1'b0;
        mm_addr = '0;
        mm_wdata = '0;
        active_channel = 2'd0;
        signal_present = 4'hF;
        err_inc = 4'h0;
        repeat (3) @(negedge rclk);
        chk("rst_rdata", mm_rdata, 32'h0);
        chk("rst_cfg_update", {31'd0, cfg_update}, 32'h0);
        cfg_chk("rst_cfg_out", 32'h0C350E40);
        rst_n = 1'b1;
        repeat (2) @(negedge rclk);

        rd(8'h00, d);
        chk("rd_cfg_reset", d, 32'h0C350E40);
        rd(8'h01, d);
        chk("rd_status_reset", d, 32'h0000003C);
        active_channel = 2'd2;
        signal_present = 4'h5;
        rd(8'h01, d);
        chk("rd_status_live", d, 32'h00000016);
        rd(8'h05, d);
        chk("rd_unmapped", d, 32'h0);

        wr(8'h00, 32'h0C350D81);
        chk("upd_pulse_hi", {31'd0, cfg_update}, 32'h1);
        chk("fallback", {31'd0, fallback_enable}, 32'h1);
        chk("manual", {31'd0, manual_enable}, 32'h0);
        chk("prio", {24'd0, channel_priority}, 32'hD8);
        chk("timer", {12'd0, reset_timer}, 32'd50000);
        @(negedge rclk);
        chk("upd_pulse_lo", {31'd0, cfg_update}, 32'h0);
        rd(8'h00, d);
        chk("rd_cfg_new", d, 32'h0C350D81);

        wr(8'h00, 32'h00010D57);
        chk("bad_prio_no_upd", {31'd0, cfg_update}, 32'h0);
        cfg_chk("bad_prio_cfg", 32'h0C350D81);
        rd(8'h01, d);
        chk("prio_err_set", d, 32'h00000056);
        wr(8'h01, 32'h00000040);
        rd(8'h01, d);
        chk("prio_err_w1c", d, 32'h00000016);
        wr(8'h07, 32'h00001E41);
        cfg_chk("wr_unmapped", 32'h0C350D81);

        // Simultaneous read and write of CONFIG returns the old value
        @(negedge rclk);
        mm_write_en = 1'b1;
        mm_read_en  = 1'b1;
        mm_addr     = 8'h00;
        mm_wdata    = 32'h00123E41;
        @(negedge rclk);
        mm_write_en = 1'b0;
        mm_read_en  = 1'b0;
        chk("rw_old_rdata", mm_rdata, 32'h0C350D81);
        cfg_chk("rw_new_cfg", 32'h00123E41);

        pulse(4'b0100, 300);
        rd(8'h02, d);
        chk("errcnt_sat", d, 32'h00FF0000);

`ifdef QOS_ERRCNT_CLEAR_ON_READ_EN
        rd(8'h02, d);
        chk("errcnt_cleared", d, 32'h0);
        pulse(4'b0001, 5);
        rd(8'h02, d);
        chk("errcnt_ch0_5", d, 32'h00000005);
        rd(8'h02, d);
        chk("errcnt_cor", d, 32'h0);
        @(negedge rclk);
        mm_read_en = 1'b1;
        mm_addr    = 8'h02;
        err_inc    = 4'b0001;
        @(negedge rclk);
        mm_read_en = 1'b0;
        err_inc    = 4'h0;
        chk("errcnt_coinc_rd", mm_rdata, 32'h0);
        rd(8'h02, d);
        chk("errcnt_coinc_inc", d, 32'h00000001);
`else
        rd(8'h02, d);
        chk("errcnt_nondestr", d, 32'h00FF0000);
        pulse(4'b0001, 5);
        rd(8'h02, d);
        chk("errcnt_ch0_5", d, 32'h00FF0005);
`endif

        // Reset asserted in the middle of a write strobe
        @(negedge rclk);
        mm_write_en = 1'b1;
        mm_addr     = 8'h00;
        mm_wdata    = 32'h00001E41;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rdata", mm_rdata, 32'h0);
        cfg_chk("midrst_cfg", 32'h0C350E40);
        @(negedge rclk);
        mm_write_en = 1'b0;
        rst_n = 1'b1;
        @(negedge rclk);
        cfg_chk("postrst_cfg", 32'h0C350E40);
        chk("postrst_upd", {31'd0, cfg_update}, 32'h0);
        rd(8'h02, d);
        chk("postrst_errcnt", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
